// File: rtl/mult_bist_ctrl.sv
// mult_bist_ctrl: LFSR-driven BIST controller for a 64x64 multiplier with a 128-bit MISR (ports: clk, rst, start, abort, golden, f_i -> a_o, b_o, busy, done, pass, signature, pat_cnt)
module mult_bist_ctrl #(
  parameter int N_PATTERNS = 256,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] golden,
  input  logic [127:0] f_i,
  output logic [63:0]  a_o,
  output logic [63:0]  b_o,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [127:0] signature,
  output logic [15:0]  pat_cnt
);
  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;
  state_t state, nxt;
  logic [63:0] lfsr, lfsr_nxt;
  logic [3:0] settle_cnt;
  logic [127:0] sig_nxt;
  logic [15:0] cnt_inc;
  logic [7:0] bpat;
  logic idle_like, run, last;
  always_comb begin
    idle_like = state == IDLE || state == DONE;
    run = state == APPLY || state == CAPTURE;
    sig_nxt = {signature[126:0], signature[127] ^ signature[28] ^ signature[26] ^ signature[1]} ^ f_i;
    lfsr_nxt = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
    cnt_inc = pat_cnt + 16'd1;
    last = cnt_inc == 16'(N_PATTERNS);
    bpat = cnt_inc[7:6] == 2'd0 ? 8'hAA : cnt_inc[7:6] == 2'd1 ? 8'h55 : cnt_inc[7:6] == 2'd2 ? 8'hFF : 8'h0F;
    nxt = idle_like ? (start ? APPLY : state)
        : abort ? IDLE
        : state == APPLY ? (settle_cnt == 4'(SETTLE - 1) ? CAPTURE : APPLY)
        : last ? DONE : APPLY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr <= 64'h1;
      settle_cnt <= '0;
      signature <= '0;
      pat_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      a_o <= '0;
      b_o <= '0;
    end else begin
      state <= nxt;
      busy <= nxt == APPLY || nxt == CAPTURE;
      if (idle_like && start) begin
        lfsr <= 64'h1;
        signature <= '0;
        pat_cnt <= '0;
        settle_cnt <= '0;
        done <= 1'b0;
        pass <= 1'b0;
        a_o <= 64'h1;
        b_o <= {56'b0, 8'hAA};
      end else if (run && abort) begin
        done <= 1'b0;
        pass <= 1'b0;
        a_o <= '0;
        b_o <= '0;
      end else if (state == APPLY) begin
        settle_cnt <= nxt == CAPTURE ? 4'd0 : settle_cnt + 4'd1;
      end else if (state == CAPTURE) begin
        signature <= sig_nxt;
        lfsr <= lfsr_nxt;
        pat_cnt <= cnt_inc;
        settle_cnt <= '0;
        done <= last;
        pass <= last && sig_nxt == golden;
        a_o <= last ? 64'd0 : lfsr_nxt;
        b_o <= last ? 64'd0 : {56'b0, bpat};
      end
    end
  end
endmodule

// File: tb/tb_mult_bist_ctrl.sv
// tb_mult_bist_ctrl: scoreboard bench for mult_bist_ctrl with three configurations (N=4/S=1, N=2/S=2, N=256/S=1)
module tb_mult_bist_ctrl;
  typedef struct {
    int idx;
    logic [127:0] sig;
    logic pass;
    logic [15:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic [2:0] start = 3'b111;
  logic [127:0] golden = '0;
  logic [127:0] fval = 128'h1;
  logic [63:0] a [3];
  logic [63:0] b [3];
  logic [127:0] f [3];
  logic [127:0] sig [3];
  logic [15:0] cnt [3];
  logic [2:0] busy, done, pass;
  exp_t q[$];
  int vec = 0;
  int err = 0;
  int bc;
  logic [127:0] m2, m256;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int NP = g == 0 ? 4 : g == 1 ? 2 : 256;
    localparam int ST = g == 1 ? 2 : 1;
    assign f[g] = g == 0 ? 128'd0 : g == 1 ? fval : a[g] * b[g];
    mult_bist_ctrl #(.N_PATTERNS(NP), .SETTLE(ST)) dut (
      .clk(clk), .rst(rst), .start(start[g]), .abort(abort), .golden(golden), .f_i(f[g]),
      .a_o(a[g]), .b_o(b[g]), .busy(busy[g]), .done(done[g]), .pass(pass[g]),
      .signature(sig[g]), .pat_cnt(cnt[g])
    );
  end
  function automatic logic [7:0] bp(int k);
    case ((k >> 6) & 3)
      0: return 8'hAA;
      1: return 8'h55;
      2: return 8'hFF;
      default: return 8'h0F;
    endcase
  endfunction
  function automatic logic [63:0] adv(logic [63:0] l);
    return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
  endfunction
  function automatic logic [127:0] model(int n);
    logic [63:0] l = 64'h1;
    logic [127:0] s = '0;
    logic [127:0] p;
    for (int k = 0; k < n; k++) begin
      p = {64'b0, l} * {120'b0, bp(k)};
      s = {s[126:0], s[127] ^ s[28] ^ s[26] ^ s[1]} ^ p;
      l = adv(l);
    end
    return s;
  endfunction
  task automatic chk(string n, logic [127:0] act, logic [127:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask
  task automatic chk_rst(int i);
    chk("rst_a", a[i], 0);
    chk("rst_b", b[i], 0);
    chk("rst_busy", busy[i], 0);
    chk("rst_done", done[i], 0);
    chk("rst_pass", pass[i], 0);
    chk("rst_sig", sig[i], 0);
    chk("rst_cnt", cnt[i], 0);
  endtask
  task automatic monitor();
    logic [2:0] pd = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done[i] && !pd[i]) begin
          if (q.size() == 0) begin
            vec++;
            err++;
            $display("FAIL mon_unexpected_done: instance %0d, expected no completion", i);
          end else begin
            e = q.pop_front();
            chk("mon_idx", i, e.idx);
            chk("mon_sig", sig[i], e.sig);
            chk("mon_pass", pass[i], e.pass);
            chk("mon_cnt", cnt[i], e.cnt);
          end
        end
        pd[i] = done[i];
      end
    end
  endtask
  task automatic pulse(int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask
  task automatic run(int i, int s, output int n);
    logic [63:0] l = 64'h1;
    int p;
    n = 0;
    pulse(i);
    while (busy[i] && n < 5000) begin
      p = n / (s + 1);
      chk("run_a", a[i], l);
      chk("run_b", b[i], {56'b0, bp(p)});
      chk("run_cnt", cnt[i], p);
      n++;
      if (n % (s + 1) == 0) l = adv(l);
      @(negedge clk);
    end
  endtask
  initial begin
    m2 = model(2);
    m256 = model(256);
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_rst(i);
    rst = 1'b0;
    start = '0;
    repeat (2) @(negedge clk);
    chk("rst_no_run", busy, 0);
    golden = '0;
    q.push_back('{0, 128'h0, 1'b1, 16'd4});
    run(0, 1, bc);
    chk("n4_busy_cycles", bc, 8);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_done_done", done[0], 1);
    chk("abort_in_done_cnt", cnt[0], 4);
    fval = 128'h1;
    golden = 128'h3;
    q.push_back('{1, 128'h3, 1'b1, 16'd2});
    run(1, 2, bc);
    chk("n2_busy_cycles", bc, 6);
    golden = 128'h2;
    q.push_back('{1, 128'h3, 1'b0, 16'd2});
    run(1, 2, bc);
    chk("n2_rerun_busy_cycles", bc, 6);
    golden = m256;
    q.push_back('{2, m256, 1'b1, 16'd256});
    run(2, 1, bc);
    chk("n256_busy_cycles", bc, 512);
    pulse(2);
    repeat (2) @(negedge clk);
    pulse(2);
    repeat (2) @(negedge clk);
    chk("abort_pre_cnt", cnt[2], 2);
    chk("abort_pre_busy", busy[2], 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy[2], 0);
    chk("abort_done", done[2], 0);
    chk("abort_pass", pass[2], 0);
    chk("abort_cnt", cnt[2], 2);
    chk("abort_sig", sig[2], m2);
    chk("abort_a", a[2], 0);
    chk("abort_b", b[2], 0);
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    chk("abort_idle_cnt", cnt[2], 2);
    chk("abort_idle_sig", sig[2], m2);
    pulse(2);
    repeat (8) @(negedge clk);
    chk("rst_mid_cnt_pre", cnt[2], 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_rst(2);
    golden = m256;
    q.push_back('{2, m256, 1'b1, 16'd256});
    run(2, 1, bc);
    chk("rst_rerun_busy_cycles", bc, 512);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/mult_bist_ctrl.md
MULT_BIST_CTRL -- requirements
Module: mult_bist_ctrl

Interface
REQ-001 SHALL provide parameter N_PATTERNS, default 256, number of patterns applied per run (range 1..65535).
REQ-002 SHALL provide parameter SETTLE, default 1, cycles each pattern is held before capture (range 1..15).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  single-cycle run request.
REQ-006 SHALL have port abort  in  1  terminate run, return to idle.
REQ-007 SHALL have port golden  in  128  expected final signature.
REQ-008 SHALL have port f_i  in  128  product from 64x64 multiplier under test.
REQ-009 SHALL have port a_o  out  64  multiplicand driven to multiplier.
REQ-010 SHALL have port b_o  out  64  multiplier operand driven to multiplier.
REQ-011 SHALL have port busy  out  1  run in progress.
REQ-012 SHALL have port done  out  1  run completed, result valid.
REQ-013 SHALL have port pass  out  1  signature equals golden; meaningful only while done=1.
REQ-014 SHALL have port signature  out  128  MISR contents.
REQ-015 SHALL have port pat_cnt  out  16  patterns captured so far in current run.

Function
REQ-016 SHALL implement FSM states IDLE, APPLY, CAPTURE, DONE; all outputs registered.
REQ-017 SHALL, in IDLE or DONE with start=1, load LFSR=64'h1, signature=0, pat_cnt=0, settle counter=0, clear done/pass, enter APPLY next cycle.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL drive a_o=LFSR and b_o={56'b0, bpat} in APPLY and CAPTURE; a_o=b_o=0 in IDLE and DONE.
REQ-020 SHALL select bpat from pat_cnt[7:6]: 0->8'hAA, 1->8'h55, 2->8'hFF, 3->8'h0F (wraps every 256 patterns).
REQ-021 SHALL hold APPLY for exactly SETTLE cycles, then enter CAPTURE for exactly one cycle; each pattern costs SETTLE+1 cycles.
REQ-022 SHALL, in CAPTURE, update signature = {signature[126:0], fb} XOR f_i, fb = signature[127]^signature[28]^signature[26]^signature[1].
REQ-023 SHALL, in CAPTURE, advance LFSR = {LFSR[62:0], LFSR[63]^LFSR[62]^LFSR[60]^LFSR[59]} and increment pat_cnt.
REQ-024 SHALL go CAPTURE->DONE when incremented pat_cnt equals N_PATTERNS, else CAPTURE->APPLY.
REQ-025 SHALL, on entry to DONE, set done=1 and pass=(final signature==golden); hold both, signature and pat_cnt until start, abort-independent, or rst.
REQ-026 SHALL assert busy=1 exactly in APPLY and CAPTURE.
REQ-027 SHALL, on abort=1 in APPLY/CAPTURE, enter IDLE next cycle with done=0, pass=0, a_o=b_o=0; signature and pat_cnt retain last values; abort in IDLE/DONE has no effect.
REQ-028 SHALL give abort priority over CAPTURE update in the same cycle (no signature/pat_cnt change).
REQ-029 SHALL give rst priority over start and abort.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, set state=IDLE, a_o=0, b_o=0, busy=0, done=0, pass=0, signature=0, pat_cnt=0, LFSR=64'h1.
REQ-031 SHALL, on rst asserted mid-run, discard the run fully; next start begins a fresh run.

Verification
REQ-032 Reset: assert rst 2 cycles with start=1 -> all outputs 0, state IDLE, no run starts.
REQ-033 N_PATTERNS=4, SETTLE=1, f_i=0, golden=0: pulse start -> busy high 8 cycles, a_o sequence 1,2,4,8, b_o=64'hAA, then done=1, pass=1, pat_cnt=4, signature=0.
REQ-034 N_PATTERNS=2, SETTLE=2, f_i=128'h1, golden=128'h3 -> each pattern held 3 cycles, final signature=128'h3, pass=1; rerun with golden=128'h2 -> pass=0.
REQ-035 N_PATTERNS=256, SETTLE=1: b_o low byte AA/55/FF/0F at pat_cnt 0/64/128/192; done after 512 busy cycles, pat_cnt=256.
REQ-036 Abort in CAPTURE of pattern 3 -> IDLE next cycle, pat_cnt=2 retained, done=0; start pulsed while busy -> ignored, no restart.
REQ-037 rst mid-run at pattern 5 -> all reset values; subsequent start yields signature identical to uninterrupted run.
